game_session_arbiter: RTL and testbench

//  Shares one Game_State instance between NUM_PLAYERS requesters.
//  - Round-robin picks one requesting player and loads its start value into the game (INIT + i_value).
//  - Drives that player's counting mode on control until a result occurs, then reports it.
//  - Pulses the game reset between sessions so every player starts from a clean game.
//  - Sits between the player front-ends and the game interface signals.

---
 rtl/game_arb_pkg.sv | 29 ++
 rtl/game_session_arbiter_if.sv | 47 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/game_session_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_game_session_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_arb_pkg.sv
// Shared types and constants for the game session arbiter.
//   state_e  : session sequencer states
//   result_e : how a session ended, as reported on done_result
//   STAT_W   : width of each per-player win counter
//   sat_inc  : saturating increment used by the win counters
package game_arb_pkg;

    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        RES_TIMEOUT,
        RES_LOSE,
        RES_WIN,
        RES_ABORT
    } result_e;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/game_session_arbiter_if.sv
// Bundle of player-side and game-side signals around the arbiter.
//   master : the environment (players + Game_State) - drives requests and game results
//   slave  : the arbiter - drives grant, game control and completion reports
// Signals:
//   req/start_val/mode          player requests, start values, counting modes
//   grant                       one-hot owner of the game
//   game_rst/init/value/ctrl    controls toward Game_State
//   win_in/los_in/gameover_in   results from Game_State
//   done_valid/player/result    session-complete report
//   win_count                   per-player win totals (zero when statistics are off)
interface game_session_arbiter_if #(
    parameter int NUM_PLAYERS  = 4,
    parameter int COUNTER_SIZE = 4
);
    import game_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_PLAYERS);

    logic [NUM_PLAYERS-1:0]              req;
    logic [NUM_PLAYERS*COUNTER_SIZE-1:0] start_val;
    logic [NUM_PLAYERS*2-1:0]            mode;
    logic [NUM_PLAYERS-1:0]              grant;
    logic                                game_rst;
    logic                                game_init;
    logic [COUNTER_SIZE-1:0]             game_value;
    logic [1:0]                          game_ctrl;
    logic                                win_in;
    logic                                los_in;
    logic                                gameover_in;
    logic                                done_valid;
    logic [IDX_W-1:0]                    done_player;
    logic [1:0]                          done_result;
    logic [NUM_PLAYERS*STAT_W-1:0]       win_count;

    modport master (
        output req, start_val, mode, win_in, los_in, gameover_in,
        input  grant, game_rst, game_init, game_value, game_ctrl,
               done_valid, done_player, done_result, win_count
    );

    modport slave (
        input  req, start_val, mode, win_in, los_in, gameover_in,
        output grant, game_rst, game_init, game_value, game_ctrl,
               done_valid, done_player, done_result, win_count
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i    : request vector
//   ptr_i    : index of the last winner; search starts at ptr_i+1 and wraps
//   any_o    : at least one request is set
//   idx_o    : index of the chosen requester
//   onehot_o : chosen requester as a one-hot vector (zero when any_o is low)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    logic [IDX_W-1:0] cand;

    // Walk the candidates from farthest to nearest so the nearest set bit
    // after the pointer is the last one written and therefore wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot_o[gi] = any_o && (idx_o == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/game_session_arbiter.sv
// Shares one Game_State instance between NUM_PLAYERS requesters.
// A round-robin pick grants the game to one player, loads its start value,
// follows its counting mode until a result, timeout or abort, reports the
// outcome for one cycle and pulses the game reset before the next session.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : game_session_arbiter_if.slave (players, Game_State, reports)
// Build option:
//   GAME_ARB_STATS_EN - when defined, per-player saturating 8-bit win counters
//                       drive win_count; otherwise win_count is tied to zero.
module game_session_arbiter
    import game_arb_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int COUNTER_SIZE = 4,
    parameter int MAX_TURN     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    game_session_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PLAYERS);
    localparam int TC_W  = $clog2(MAX_TURN) + 1;

    // Per-player views of the packed input buses.
    logic [COUNTER_SIZE-1:0] start_val_arr [NUM_PLAYERS];
    logic [1:0]              mode_arr      [NUM_PLAYERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_unpack
            assign start_val_arr[gi] = bus.start_val[gi*COUNTER_SIZE +: COUNTER_SIZE];
            assign mode_arr[gi]      = bus.mode[gi*2 +: 2];
        end
    endgenerate

    state_e                  state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        g_idx_q;
    logic [NUM_PLAYERS-1:0]  grant_q;
    logic [TC_W-1:0]         turn_cnt_q;
    result_e                 res_q;
    logic                    game_rst_q;
    logic                    game_init_q;
    logic [COUNTER_SIZE-1:0] game_value_q;
    logic [1:0]              game_ctrl_q;
    logic                    done_valid_q;
    logic [IDX_W-1:0]        done_player_q;
    result_e                 done_result_q;

    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_PLAYERS-1:0]  pick_onehot;

    rr_arbiter #(
        .N     (NUM_PLAYERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // Session exit decision for the current PLAY cycle. The order of the
    // checks is the priority: abort beats any game result, gameover beats
    // the individual win/lose flags, and timeout only applies when nothing
    // else happened.
    logic    play_exit;
    result_e play_res;

    always_comb begin
        play_exit = 1'b1;
        play_res  = RES_TIMEOUT;
        if (!bus.req[g_idx_q]) begin
            play_res = RES_ABORT;
        end else if (bus.gameover_in) begin
            play_res = bus.win_in ? RES_WIN : RES_LOSE;
        end else if (bus.win_in) begin
            play_res = RES_WIN;
        end else if (bus.los_in) begin
            play_res = RES_LOSE;
        end else if (turn_cnt_q == TC_W'(MAX_TURN - 1)) begin
            play_res = RES_TIMEOUT;
        end else begin
            play_exit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(NUM_PLAYERS - 1);
            g_idx_q       <= '0;
            grant_q       <= '0;
            turn_cnt_q    <= '0;
            res_q         <= RES_TIMEOUT;
            game_rst_q    <= 1'b1;
            game_init_q   <= 1'b0;
            game_value_q  <= '0;
            game_ctrl_q   <= '0;
            done_valid_q  <= 1'b0;
            done_player_q <= '0;
            done_result_q <= RES_TIMEOUT;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    game_rst_q <= 1'b0;
                    if (pick_any) begin
                        grant_q <= pick_onehot;
                        g_idx_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // Game results in this cycle belong to the previous game
                    // and are deliberately not looked at.
                    game_init_q  <= 1'b1;
                    game_value_q <= start_val_arr[g_idx_q];
                    game_ctrl_q  <= mode_arr[g_idx_q];
                    turn_cnt_q   <= '0;
                    state_q      <= PLAY;
                end
                PLAY: begin
                    game_init_q <= 1'b0;
                    game_ctrl_q <= mode_arr[g_idx_q];
                    // Exit is forced at MAX_TURN-1, so this never wraps.
                    turn_cnt_q  <= turn_cnt_q + 1'b1;
                    if (play_exit) begin
                        res_q   <= play_res;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_valid_q  <= 1'b1;
                    done_player_q <= g_idx_q;
                    done_result_q <= res_q;
                    grant_q       <= '0;
                    game_rst_q    <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.game_rst    = game_rst_q;
    assign bus.game_init   = game_init_q;
    assign bus.game_value  = game_value_q;
    assign bus.game_ctrl   = game_ctrl_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_player = done_player_q;
    assign bus.done_result = done_result_q;

`ifdef GAME_ARB_STATS_EN
    // Counted while in DONE so the total moves together with done_valid.
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_stat
            logic [STAT_W-1:0] win_cnt_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    win_cnt_q <= '0;
                end else if (state_q == DONE && res_q == RES_WIN &&
                             g_idx_q == IDX_W'(gi)) begin
                    win_cnt_q <= sat_inc(win_cnt_q);
                end
            end
            assign bus.win_count[gi*STAT_W +: STAT_W] = win_cnt_q;
        end
    endgenerate
`else
    assign bus.win_count = '0;
`endif

endmodule

// File: tb/tb_game_session_arbiter.sv
// Self-checking bench for game_session_arbiter: a reset/first-session vector
// table, hand-written corner sequences and a randomized phase, all checked
// every cycle against a session-level reference model.
module tb_game_session_arbiter;
    import game_arb_pkg::*;

    localparam int NP = 4;
    localparam int CS = 4;
    localparam int MT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_session_arbiter_if #(.NUM_PLAYERS(NP), .COUNTER_SIZE(CS)) bus ();

    game_session_arbiter #(
        .NUM_PLAYERS  (NP),
        .COUNTER_SIZE (CS),
        .MAX_TURN     (MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Session view: who owns the game, how many play turns have elapsed
    // (-1 = start value not yet loaded) and a pending result to report.
    int m_owner, m_plays, m_pending, m_last;
    int e_grant, e_rst, e_init, e_value, e_ctrl, e_done, e_player, e_result;
    int wins [NP];

    task automatic model_edge();
        int r;
        logic [31:0] rq;
        rq = 32'(bus.req);
        if (reset) begin
            m_owner = -1; m_pending = -1; m_last = NP - 1; m_plays = -1;
            e_grant = 0; e_rst = 1; e_init = 0; e_value = 0; e_ctrl = 0;
            e_done = 0; e_player = 0; e_result = 0;
            for (int p = 0; p < NP; p++) wins[p] = 0;
            return;
        end
        e_done = 0;
        if (m_pending >= 0) begin
            e_done = 1; e_player = m_owner; e_result = m_pending;
            if (m_pending == 2 && wins[m_owner] < 255) wins[m_owner]++;
            e_grant = 0; e_rst = 1;
            m_owner = -1; m_pending = -1;
        end else if (m_owner < 0) begin
            e_rst = 0;
            for (int k = 1; k <= NP; k++) begin
                int c;
                c = (m_last + k) % NP;
                if (((rq >> c) & 1) != 0) begin
                    m_owner = c;
                    break;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner; e_grant = 1 << m_owner; m_plays = -1;
            end
        end else if (m_plays < 0) begin
            e_init  = 1;
            e_value = int'((bus.start_val >> (m_owner * CS)) & ((1 << CS) - 1));
            e_ctrl  = int'((bus.mode >> (m_owner * 2)) & 3);
            m_plays = 0;
        end else begin
            e_init = 0;
            e_ctrl = int'((bus.mode >> (m_owner * 2)) & 3);
            r = -1;
            if (((rq >> m_owner) & 1) == 0) r = 3;
            else if (bus.gameover_in)        r = bus.win_in ? 2 : 1;
            else if (bus.win_in)             r = 2;
            else if (bus.los_in)             r = 1;
            else if (m_plays == MT - 1)      r = 0;
            m_plays++;
            if (r >= 0) m_pending = r;
        end
    endtask

    task automatic compare_all();
        logic [31:0] wc;
        wc = 0;
`ifdef GAME_ARB_STATS_EN
        for (int p = 0; p < NP; p++) wc[p*8 +: 8] = 8'(wins[p]);
`endif
        chk("grant",       32'(bus.grant),       32'(e_grant));
        chk("game_rst",    32'(bus.game_rst),    32'(e_rst));
        chk("game_init",   32'(bus.game_init),   32'(e_init));
        chk("game_value",  32'(bus.game_value),  32'(e_value));
        chk("game_ctrl",   32'(bus.game_ctrl),   32'(e_ctrl));
        chk("done_valid",  32'(bus.done_valid),  32'(e_done));
        chk("done_player", 32'(bus.done_player), 32'(e_player));
        chk("done_result", 32'(bus.done_result), 32'(e_result));
        chk("win_count",   32'(bus.win_count),   wc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (bus.done_valid) begin
            done_cnt++;
            $display("session: player %0d result %0d", bus.done_player, bus.done_result);
        end
    endtask

    // sel: 0 = grant, 1 = game_init, 2 = done_valid
    task automatic wait_for(string name, int sel, int limit);
        int n;
        n = 0;
        while (n < limit &&
               !((sel == 0 && bus.grant != 0) || (sel == 1 && bus.game_init) ||
                 (sel == 2 && bus.done_valid))) begin
            step();
            n++;
        end
        chk(name, 32'(n < limit), 32'd1);
    endtask

    task automatic clear_inputs();
        bus.req = '0; bus.start_val = '0; bus.mode = '0;
        bus.win_in = 1'b0; bus.los_in = 1'b0; bus.gameover_in = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sv0;
        logic       win;
        logic [3:0] x_grant;
        logic       x_rst;
        logic       x_init;
        logic [3:0] x_value;
        logic       x_done;
        logic [1:0] x_result;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   n, d0, wins1, first_grant;
        bit   done_seen;

        clear_inputs();

        // First session from reset: win_in in the LOAD cycle is ignored,
        // the WIN two PLAY cycles later ends the session.
        tbl[0] = '{1'b1, 4'b0000, 4'd13, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0};
        tbl[1] = '{1'b0, 4'b0001, 4'd13, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd0,  1'b0, 2'd0};
        tbl[2] = '{1'b0, 4'b0001, 4'd13, 1'b1, 4'b0001, 1'b0, 1'b1, 4'd13, 1'b0, 2'd0};
        tbl[3] = '{1'b0, 4'b0001, 4'd13, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd13, 1'b0, 2'd0};
        tbl[4] = '{1'b0, 4'b0001, 4'd13, 1'b0, 4'b0001, 1'b0, 1'b0, 4'd13, 1'b0, 2'd0};
        tbl[5] = '{1'b0, 4'b0001, 4'd13, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd13, 1'b0, 2'd0};
        tbl[6] = '{1'b0, 4'b0001, 4'd13, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd13, 1'b1, 2'd2};
        tbl[7] = '{1'b0, 4'b0000, 4'd13, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd13, 1'b0, 2'd2};
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; bus.req = tbl[i].req;
            bus.start_val = {12'd0, tbl[i].sv0}; bus.win_in = tbl[i].win;
            step();
            chk("t1_grant",  32'(bus.grant),       32'(tbl[i].x_grant));
            chk("t1_rst",    32'(bus.game_rst),    32'(tbl[i].x_rst));
            chk("t1_init",   32'(bus.game_init),   32'(tbl[i].x_init));
            chk("t1_value",  32'(bus.game_value),  32'(tbl[i].x_value));
            chk("t1_done",   32'(bus.done_valid),  32'(tbl[i].x_done));
            chk("t1_result", 32'(bus.done_result), 32'(tbl[i].x_result));
        end

        // All players requesting, every session times out, strict rotation.
        clear_inputs(); reset = 1'b1; bus.req = 4'b1111; step(); reset = 1'b0;
        d0 = done_cnt;
        for (int s = 0; s < 5; s++) begin
            wait_for("t2_grant_wait", 0, 40);
            chk("t2_grant_order", 32'(bus.grant), 32'(1 << (s % NP)));
            if (s == 0) begin
                wait_for("t2_init_wait", 1, 10);
                n = 0;
                while (!bus.done_valid && n < 30) begin step(); n++; end
                chk("t3_timeout_latency", 32'(n), 32'(MT + 1));
            end else begin
                wait_for("t2_done_wait", 2, 40);
            end
            chk("t2_result", 32'(bus.done_result), 32'(RES_TIMEOUT));
            chk("t2_player", 32'(bus.done_player), 32'(s % NP));
        end
        chk("t2_done_count", 32'(done_cnt - d0), 32'd5);

        // Abort beats a simultaneous gameover+win.
        clear_inputs(); reset = 1'b1; step(); reset = 1'b0;
        bus.req = 4'b0100;
        wait_for("t4_grant_wait", 0, 10);
        wait_for("t4_init_wait", 1, 10);
        step();
        bus.req = 4'b0000; bus.win_in = 1'b1; bus.gameover_in = 1'b1;
        step();
        bus.win_in = 1'b0; bus.gameover_in = 1'b0;
        step();
        chk("t4_done",   32'(bus.done_valid),  32'd1);
        chk("t4_result", 32'(bus.done_result), 32'(RES_ABORT));
        chk("t4_player", 32'(bus.done_player), 32'd2);
        chk("t4_rst",    32'(bus.game_rst),    32'd1);
        step();
        chk("t4_rst_end", 32'(bus.game_rst), 32'd0);

        // Reset in the middle of PLAY.
        clear_inputs(); reset = 1'b1; step(); reset = 1'b0;
        bus.req = 4'b0011;
        wait_for("t5_grant_wait", 0, 10);
        wait_for("t5_init_wait", 1, 10);
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_grant", 32'(bus.grant),      32'd0);
        chk("t5_rst",   32'(bus.game_rst),   32'd1);
        chk("t5_done",  32'(bus.done_valid), 32'd0);
        done_seen = 1'b0; first_grant = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done_valid) done_seen = 1'b1;
            if (first_grant == 0 && bus.grant != 0) first_grant = int'(bus.grant);
        end
        chk("t5_no_done",     32'(done_seen),   32'd0);
        chk("t5_first_grant", 32'(first_grant), 32'd1);

        // Randomized phase against the model.
        clear_inputs(); reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NP; p++) begin
                if (p == m_owner) bus.req[p] = ($urandom_range(0, 49) != 0);
                else              bus.req[p] = ($urandom_range(0, 3) != 0);
            end
            bus.start_val   = 16'($urandom);
            bus.mode        = 8'($urandom);
            bus.win_in      = ($urandom_range(0, 9) == 0);
            bus.los_in      = ($urandom_range(0, 9) == 0);
            bus.gameover_in = ($urandom_range(0, 11) == 0);
            step();
        end
        reset = 1'b0;

        // Win statistics for player 1.
        clear_inputs(); reset = 1'b1; step(); reset = 1'b0;
        bus.req = 4'b0010; bus.win_in = 1'b1;
        wins1 = 0; n = 0;
        while (wins1 < 3 && n < 100) begin
            step(); n++;
            if (bus.done_valid && bus.done_player == 1 && bus.done_result == RES_WIN) wins1++;
        end
`ifdef GAME_ARB_STATS_EN
        chk("t6_wins_3", 32'(bus.win_count[15:8]), 32'd3);
`else
        chk("t6_wins_3", 32'(bus.win_count), 32'd0);
`endif
        n = 0;
        while (wins1 < 300 && n < 3000) begin
            step(); n++;
            if (bus.done_valid && bus.done_player == 1 && bus.done_result == RES_WIN) wins1++;
        end
        chk("t6_wins_reached", 32'(wins1), 32'd300);
`ifdef GAME_ARB_STATS_EN
        chk("t6_wins_sat", 32'(bus.win_count[15:8]), 32'd255);
`else
        chk("t6_wins_sat", 32'(bus.win_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
